// File: rtl/dtw_feed_pkg.sv
// Shared defaults and sample type for the DTW input feeder.
package dtw_feed_pkg;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic signed [DW-1:0] dtw_sample_t;
endpackage

// File: rtl/dtw_feed_fifo.sv
// One show-ahead feeder channel: head word is combinational, pop on the request edge.
// Sticky ovf/unf flags exist only when DTW_FEED_ERR_EN is defined.
module dtw_feed_fifo #(
  parameter int DW    = dtw_feed_pkg::DW,
  parameter int DEPTH = dtw_feed_pkg::DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_req_i,
  input  logic          clr_err_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o,
  output logic          unf_o
);
  import dtw_feed_pkg::*;

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_wr, do_rd;

  // A pop frees a slot in the same cycle, so a full channel still accepts a write.
  assign do_rd = rd_req_i & ~empty_q;
  assign do_wr = wr_en_i & (~full_q | do_rd);
  assign cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr && !rst_i) mem_q[wptr_q] <= wr_data_i;
  end

  assign head_o  = empty_q ? '0 : mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

`ifdef DTW_FEED_ERR_EN
  logic ovf_q, unf_q;
  logic ovf_evt, unf_evt;

  assign ovf_evt = wr_en_i & full_q & ~do_rd;
  assign unf_evt = rd_req_i & empty_q;

  // A new event on the clear cycle keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~clr_err_i) | ovf_evt;
      unf_q <= (unf_q & ~clr_err_i) | unf_evt;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`else
  logic unused_clr;
  assign unused_clr = clr_err_i;
  assign ovf_o      = 1'b0;
  assign unf_o      = 1'b0;
`endif
endmodule

// File: rtl/dtw_in_feeder.sv
// Three-channel show-ahead input buffer feeding the DTW processor in0/in1/in2 ports.
// Define DTW_FEED_ERR_EN to enable the sticky ovf/unf flags and clr_err.
module dtw_in_feeder #(
  parameter int DW    = dtw_feed_pkg::DW,
  parameter int DEPTH = dtw_feed_pkg::DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_geral,
  input  logic [2:0]           wr_en,
  input  logic signed [DW-1:0] wr_data0,
  input  logic signed [DW-1:0] wr_data1,
  input  logic signed [DW-1:0] wr_data2,
  input  logic [2:0]           req_in,
  output logic signed [DW-1:0] in0,
  output logic signed [DW-1:0] in1,
  output logic signed [DW-1:0] in2,
  output logic [2:0]           full,
  output logic [2:0]           empty,
  output logic [2:0]           ovf,
  output logic [2:0]           unf,
  input  logic                 clr_err
);
  import dtw_feed_pkg::*;

  logic [2:0][DW-1:0] wdata, head;

  assign wdata[0] = wr_data0;
  assign wdata[1] = wr_data1;
  assign wdata[2] = wr_data2;

  for (genvar k = 0; k < 3; k++) begin : g_ch
    dtw_feed_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk),
      .rst_i     (rst_geral),
      .wr_en_i   (wr_en[k]),
      .wr_data_i (wdata[k]),
      .rd_req_i  (req_in[k]),
      .clr_err_i (clr_err),
      .head_o    (head[k]),
      .full_o    (full[k]),
      .empty_o   (empty[k]),
      .ovf_o     (ovf[k]),
      .unf_o     (unf[k])
    );
  end

  assign in0 = head[0];
  assign in1 = head[1];
  assign in2 = head[2];
endmodule

// File: tb/tb_dtw_in_feeder.sv
// Scoreboard bench for dtw_in_feeder: per-channel expected queues, flags modelled alongside.
module tb_dtw_in_feeder;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
`ifdef DTW_FEED_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_geral;
  logic [2:0]           wr_en, req_in;
  logic signed [DW-1:0] wr_data0, wr_data1, wr_data2;
  logic signed [DW-1:0] in0, in1, in2;
  logic [2:0]           full, empty, ovf, unf;
  logic                 clr_err;

  dtw_in_feeder #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_geral(rst_geral), .wr_en(wr_en),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_data2(wr_data2),
    .req_in(req_in), .in0(in0), .in1(in1), .in2(in2),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ino [3];
  always_comb begin
    ino[0] = in0;
    ino[1] = in1;
    ino[2] = in2;
  end

  logic [DW-1:0] mq [3][$];
  logic [2:0]    m_ovf, m_unf;
  int            n_vec, n_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic post_chk();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("empty%0d", k), DW'(empty[k]), DW'(mq[k].size() == 0));
      chk($sformatf("full%0d", k),  DW'(full[k]),  DW'(mq[k].size() == DEPTH));
      chk($sformatf("ovf%0d", k),   DW'(ovf[k]),   DW'(m_ovf[k]));
      chk($sformatf("unf%0d", k),   DW'(unf[k]),   DW'(m_unf[k]));
      chk($sformatf("in%0d", k), ino[k], (mq[k].size() > 0) ? mq[k][0] : '0);
    end
  endtask

  // One clock cycle of stimulus; checks heads in the request cycle, state after the edge.
  task automatic cyc(input logic [2:0] wr, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [DW-1:0] d2, input logic [2:0] rq, input logic clr);
    logic [DW-1:0] d [3];
    logic [2:0]    evo, evu;
    d[0] = d0; d[1] = d1; d[2] = d2;
    wr_en = wr; req_in = rq; clr_err = clr;
    wr_data0 = d0; wr_data1 = d1; wr_data2 = d2;
    #1;
    evo = '0; evu = '0;
    for (int k = 0; k < 3; k++) begin
      if (rq[k]) begin
        if (mq[k].size() > 0) begin
          chk($sformatf("pop%0d", k), ino[k], mq[k][0]);
          void'(mq[k].pop_front());
        end else begin
          chk($sformatf("pop_empty%0d", k), ino[k], '0);
          evu[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (wr[k]) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(d[k]);
        else evo[k] = 1'b1;
      end
    end
    if (ERR_EN) begin
      m_ovf = (m_ovf & ~{3{clr}}) | evo;
      m_unf = (m_unf & ~{3{clr}}) | evu;
    end
    @(posedge clk); #1;
    wr_en = '0; req_in = '0; clr_err = 1'b0;
    post_chk();
  endtask

  task automatic do_reset();
    rst_geral = 1'b1;
    wr_en = 3'b111; req_in = 3'b111;
    wr_data0 = 32'sd11; wr_data1 = 32'sd22; wr_data2 = 32'sd33;
    @(posedge clk); #1;
    rst_geral = 1'b0; wr_en = '0; req_in = '0; clr_err = 1'b0;
    for (int k = 0; k < 3; k++) mq[k].delete();
    m_ovf = '0; m_unf = '0;
    post_chk();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_ovf = '0; m_unf = '0;
    rst_geral = 1'b1; wr_en = '0; req_in = '0; clr_err = 1'b0;
    wr_data0 = '0; wr_data1 = '0; wr_data2 = '0;
    @(posedge clk); #1;
    do_reset();
    cyc(3'b000, 0, 0, 0, 3'b000, 1'b0);
    chk("idle_empty", DW'(empty), DW'(3'b111));
    chk("idle_full",  DW'(full),  '0);

    // Single-word passthrough on ch1
    cyc(3'b010, 0, 32'hFFFF_FFFB, 0, 3'b000, 1'b0);
    chk("ch1_minus5", in1, 32'hFFFF_FFFB);
    cyc(3'b000, 0, 0, 0, 3'b010, 1'b0);
    chk("ch1_drained", in1, '0);

    // Fill ch0 with 0..15, overflow with 99, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(3'b001, DW'(i), 0, 0, 3'b000, 1'b0);
    chk("ch0_full", DW'(full[0]), 1);
    cyc(3'b001, 32'd99, 0, 0, 3'b000, 1'b0);
    chk("ch0_ovf", DW'(ovf[0]), DW'(ERR_EN));
    for (int i = 0; i < DEPTH; i++) begin
      chk("ch0_order", in0, DW'(i));
      cyc(3'b000, 0, 0, 0, 3'b001, 1'b0);
    end

    // Full ch2 with simultaneous write and pop
    for (int i = 0; i < DEPTH; i++) cyc(3'b100, 0, 0, DW'(200 + i), 3'b000, 1'b0);
    cyc(3'b100, 0, 0, 32'd100, 3'b100, 1'b0);
    chk("ch2_still_full", DW'(full[2]), 1);
    chk("ch2_no_ovf", DW'(ovf[2]), '0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("ch2_last100", in2, 32'd100);
      cyc(3'b000, 0, 0, 0, 3'b100, 1'b0);
    end

    // Empty ch0 with simultaneous request and write of 7
    cyc(3'b001, 32'd7, 0, 0, 3'b001, 1'b0);
    chk("ch0_unf", DW'(unf[0]), DW'(ERR_EN));
    chk("ch0_seven", in0, 32'd7);

    // Clear, then clear colliding with a new underflow on ch1
    cyc(3'b000, 0, 0, 0, 3'b000, 1'b1);
    cyc(3'b000, 0, 0, 0, 3'b010, 1'b1);
    chk("clr_vs_evt", DW'(unf[1]), DW'(ERR_EN));
    cyc(3'b000, 0, 0, 0, 3'b000, 1'b1);

    // Reset with 5 words buffered in ch1
    for (int i = 0; i < 5; i++) cyc(3'b010, 0, DW'(50 + i), 0, 3'b000, 1'b0);
    do_reset();
    chk("rst_empty1", DW'(empty[1]), 1);
    chk("rst_in1", in1, '0);

    // Random mixed traffic
    for (int i = 0; i < 400; i++)
      cyc(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
          3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
